// File: rtl/fpnew_pkg.sv
// Shared FPU package: IEEE exception status type and flag count.
package fpnew_pkg;

    // IEEE 754 exception flags, MSB to LSB: invalid, div-by-zero, overflow, underflow, inexact
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    localparam int unsigned NUM_STATUS_FLAGS = 5;

endpackage

// File: rtl/fpnew_fflags_accu.sv
// Sticky IEEE exception flag accumulator for the CSR fflags field.
// The body exists only when FPNEW_FLAG_ACCUM_EN is defined, so the default
// build carries no unused module.
`ifdef FPNEW_FLAG_ACCUM_EN
module fpnew_fflags_accu
    import fpnew_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        pop_i,
    input  logic                        clear_i,
    input  logic [NUM_STATUS_FLAGS-1:0] status_i,
    output logic [NUM_STATUS_FLAGS-1:0] flags_o
);

    logic [NUM_STATUS_FLAGS-1:0] r_flags;
    logic [NUM_STATUS_FLAGS-1:0] w_flags_nxt;

    // Clear acts on the old value, so a same-cycle pop leaves only the popped status.
    always_comb begin
        w_flags_nxt = r_flags;
        if (clear_i && pop_i) begin
            w_flags_nxt = status_i;
        end else if (clear_i) begin
            w_flags_nxt = '0;
        end else if (pop_i) begin
            w_flags_nxt = r_flags | status_i;
        end else begin
            w_flags_nxt = r_flags;
        end
    end

    // Flag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags_nxt;
        end
    end

    assign flags_o = r_flags;

endmodule
`endif

// File: rtl/fpnew_result_fifo_chk.sv
// Protocol checker for fpnew_result_fifo: depth range, no push when full,
// no pop when empty, stable upstream payload while stalled.
module fpnew_result_fifo_chk #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned CntW     = 3,
    parameter int unsigned PayloadW = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    input  logic                in_ready_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [CntW-1:0]     count_i,
    input  logic [PayloadW-1:0] payload_i
);

    a_depth_range: assert property (@(posedge clk_i) (Depth >= 2) && (Depth <= 16));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        (count_i == CntW'(Depth)) |-> !push_i);

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        (count_i == {CntW{1'b0}}) |-> !pop_i);

    a_stable_payload: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        (in_valid_i && !in_ready_i) |=> (in_valid_i && $stable(payload_i)));

endmodule

// File: rtl/fpnew_result_fifo.sv
// In-order result buffer between the FPU result arbiter and a slow writeback port.
// Stores {result, status, tag}; no fall-through, so a push into an empty
// buffer is visible one cycle later. Optional sticky fflags accumulation is
// enabled with the FPNEW_FLAG_ACCUM_EN macro.
module fpnew_result_fifo
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [Width-1:0]            result_i,
    input  logic [NUM_STATUS_FLAGS-1:0] status_i,
    input  TagType                      tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [Width-1:0]            result_o,
    output logic [NUM_STATUS_FLAGS-1:0] status_o,
    output TagType                      tag_o,
    output logic [$clog2(Depth+1)-1:0]  usage_o,
    output logic [NUM_STATUS_FLAGS-1:0] flags_o,
    input  logic                        flags_clear_i
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        TagType           tag;
    } entry_t;

    entry_t          r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic [PtrW-1:0] w_wr_ptr_nxt;
    logic [PtrW-1:0] w_rd_ptr_nxt;
    logic [CntW-1:0] w_count_nxt;
    logic            w_push;
    logic            w_pop;
    entry_t          w_entry;
    entry_t          w_head;

    // Non-power-of-two depths need an explicit wrap instead of natural overflow.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == LastPtr) begin
            return '0;
        end else begin
            return ptr + PtrW'(1);
        end
    endfunction

    // Ready/valid depend only on the occupancy register.
    assign in_ready_o  = (r_count != FullCnt);
    assign out_valid_o = (r_count != {CntW{1'b0}});
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    assign w_entry     = '{result: result_i, status: status_i, tag: tag_i};
    assign w_head      = r_mem[r_rd_ptr];
    assign result_o    = w_head.result;
    assign status_o    = w_head.status;
    assign tag_o       = w_head.tag;
    assign usage_o     = r_count;

    // Next pointer/occupancy; flush wins over any same-cycle handshake.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (flush_i) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - CntW'(1);
            end else begin
                w_count_nxt = r_count;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

`ifdef FPNEW_FLAG_ACCUM_EN
    logic w_pop_commit;
    assign w_pop_commit = w_pop & ~flush_i;

    fpnew_fflags_accu u_fflags_accu (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .pop_i    (w_pop_commit),
        .clear_i  (flags_clear_i),
        .status_i (status_o),
        .flags_o  (flags_o)
    );
`else
    logic w_unused_flags_clear;
    assign w_unused_flags_clear = flags_clear_i;
    assign flags_o = '0;
`endif

    fpnew_result_fifo_chk #(
        .Depth    (Depth),
        .CntW     (CntW),
        .PayloadW ($bits(entry_t))
    ) u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_i (in_ready_o),
        .push_i     (w_push),
        .pop_i      (w_pop),
        .count_i    (r_count),
        .payload_i  (w_entry)
    );

endmodule

// File: tb/tb_fpnew_result_fifo.sv
// Self-checking bench for fpnew_result_fifo: a Depth=4 instance driven by a
// directed vector table plus hand sequences, and a Depth=3 instance driven
// randomly against a queue scoreboard.
module tb_fpnew_result_fifo;

`ifdef FPNEW_FLAG_ACCUM_EN
    localparam bit FlagsOn = 1'b1;
`else
    localparam bit FlagsOn = 1'b0;
`endif
    localparam logic [63:0] ResBase = 64'hA5A5_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Depth=4 instance
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flags_clear;
    logic [63:0] a_result, a_result_o;
    logic [4:0]  a_status, a_status_o, a_flags;
    logic [7:0]  a_tag, a_tag_o;
    logic [2:0]  a_usage;

    // Depth=3 instance
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flags_clear;
    logic [63:0] b_result, b_result_o;
    logic [4:0]  b_status, b_status_o, b_flags;
    logic [7:0]  b_tag, b_tag_o;
    logic [1:0]  b_usage;

    fpnew_result_fifo #(.Width(64), .Depth(4), .TagType(logic [7:0])) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .result_i(a_result), .status_i(a_status), .tag_i(a_tag),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .result_o(a_result_o), .status_o(a_status_o), .tag_o(a_tag_o),
        .usage_o(a_usage), .flags_o(a_flags), .flags_clear_i(a_flags_clear)
    );

    fpnew_result_fifo #(.Width(64), .Depth(3), .TagType(logic [7:0])) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .result_i(b_result), .status_i(b_status), .tag_i(b_tag),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .result_o(b_result_o), .status_o(b_status_o), .tag_o(b_tag_o),
        .usage_o(b_usage), .flags_o(b_flags), .flags_clear_i(b_flags_clear)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       in_valid;
        logic       out_ready;
        logic [7:0] tag;
        logic [4:0] status;
        logic       exp_out_valid;
        logic       exp_in_ready;
        logic [2:0] exp_usage;
        logic [7:0] exp_tag;
        logic [4:0] exp_flags;
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  status;
        logic [7:0]  tag;
    } sb_t;

    vec_t tbl [10];
    sb_t  sb [$];

    initial begin
        bit         do_push, do_pop, hold;
        logic [1:0] usage_before;
        logic [4:0] b_exp_flags;

        // Fill/drain with a held in_valid while full; expectations after each edge.
        tbl[0] = '{1'b1, 1'b0, 8'd1, 5'b00001, 1'b1, 1'b1, 3'd1, 8'd1, 5'b00000};
        tbl[1] = '{1'b1, 1'b0, 8'd2, 5'b10000, 1'b1, 1'b1, 3'd2, 8'd1, 5'b00000};
        tbl[2] = '{1'b1, 1'b0, 8'd3, 5'b00100, 1'b1, 1'b1, 3'd3, 8'd1, 5'b00000};
        tbl[3] = '{1'b1, 1'b0, 8'd4, 5'b00010, 1'b1, 1'b0, 3'd4, 8'd1, 5'b00000};
        tbl[4] = '{1'b1, 1'b0, 8'd5, 5'b00000, 1'b1, 1'b0, 3'd4, 8'd1, 5'b00000};
        tbl[5] = '{1'b1, 1'b1, 8'd5, 5'b00000, 1'b1, 1'b1, 3'd3, 8'd2, 5'b00001};
        tbl[6] = '{1'b1, 1'b1, 8'd5, 5'b00000, 1'b1, 1'b1, 3'd3, 8'd3, 5'b10001};
        tbl[7] = '{1'b0, 1'b1, 8'd5, 5'b00000, 1'b1, 1'b1, 3'd2, 8'd4, 5'b10101};
        tbl[8] = '{1'b0, 1'b1, 8'd5, 5'b00000, 1'b1, 1'b1, 3'd1, 8'd5, 5'b10111};
        tbl[9] = '{1'b0, 1'b1, 8'd5, 5'b00000, 1'b0, 1'b1, 3'd0, 8'd0, 5'b10111};

        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flags_clear = 1'b0;
        a_result = '0; a_status = '0; a_tag = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_flags_clear = 1'b0;
        b_result = '0; b_status = '0; b_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_usage", 64'(a_usage), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_flags", 64'(a_flags), 64'd0);
        check("rst_b_usage", 64'(b_usage), 64'd0);
        rst = 1'b0;

        // Table-driven fill/drain and flag accumulation.
        for (int i = 0; i < 10; i++) begin
            a_in_valid  = tbl[i].in_valid;
            a_out_ready = tbl[i].out_ready;
            a_tag       = tbl[i].tag;
            a_status    = tbl[i].status;
            a_result    = ResBase | {56'd0, tbl[i].tag};
            tick();
            check($sformatf("tbl%0d_usage", i), 64'(a_usage), 64'(tbl[i].exp_usage));
            check($sformatf("tbl%0d_out_valid", i), 64'(a_out_valid), 64'(tbl[i].exp_out_valid));
            check($sformatf("tbl%0d_in_ready", i), 64'(a_in_ready), 64'(tbl[i].exp_in_ready));
            check($sformatf("tbl%0d_flags", i), 64'(a_flags), FlagsOn ? 64'(tbl[i].exp_flags) : 64'd0);
            if (tbl[i].exp_out_valid) begin
                check($sformatf("tbl%0d_tag", i), 64'(a_tag_o), 64'(tbl[i].exp_tag));
                check($sformatf("tbl%0d_result", i), a_result_o, ResBase | {56'd0, tbl[i].exp_tag});
            end
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;

        // Flag clear together with a pop of status 00100.
        a_in_valid = 1'b1; a_tag = 8'd6; a_status = 5'b00100; a_result = ResBase | 64'd6;
        tick();
        a_in_valid = 1'b0;
        check("clr_head_status", 64'(a_status_o), 64'h04);
        a_out_ready = 1'b1; a_flags_clear = 1'b1;
        tick();
        a_out_ready = 1'b0; a_flags_clear = 1'b0;
        check("clr_pop_flags", 64'(a_flags), FlagsOn ? 64'h04 : 64'd0);
        check("clr_pop_usage", 64'(a_usage), 64'd0);

        // Latency: no fall-through into an empty buffer.
        a_in_valid = 1'b1; a_tag = 8'd7; a_status = 5'b00000; a_result = 64'hDEAD_BEEF;
        #1;
        check("lat_same_cycle_valid", 64'(a_out_valid), 64'd0);
        tick();
        a_in_valid = 1'b0;
        check("lat_next_valid", 64'(a_out_valid), 64'd1);
        check("lat_next_result", a_result_o, 64'hDEAD_BEEF);

        // Flush with a same-cycle push: both entries and the push are dropped.
        a_in_valid = 1'b1; a_tag = 8'd8; a_result = ResBase | 64'd8;
        tick();
        check("fl_usage_before", 64'(a_usage), 64'd2);
        a_flush = 1'b1; a_tag = 8'd9; a_result = ResBase | 64'd9;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fl_usage", 64'(a_usage), 64'd0);
        check("fl_out_valid", 64'(a_out_valid), 64'd0);
        check("fl_flags_kept", 64'(a_flags), FlagsOn ? 64'h04 : 64'd0);
        tick();
        check("fl_usage_later", 64'(a_usage), 64'd0);
        check("fl_out_valid_later", 64'(a_out_valid), 64'd0);

        // Reset mid-stream with 3 entries stored.
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1; a_tag = 8'(10 + k); a_result = ResBase | 64'(10 + k);
            tick();
        end
        a_in_valid = 1'b0;
        check("mid_usage_before", 64'(a_usage), 64'd3);
        check("mid_head_tag", 64'(a_tag_o), 64'd10);
        rst = 1'b1;
        #1;
        check("mid_rst_usage", 64'(a_usage), 64'd0);
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("mid_rst_flags", 64'(a_flags), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Random traffic on the Depth=3 instance against a queue scoreboard.
        hold = 1'b0;
        b_exp_flags = 5'b00000;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!hold) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_result   = {$urandom, $urandom};
                b_status   = 5'($urandom_range(0, 31));
                b_tag      = 8'($urandom_range(0, 255));
            end
            b_out_ready = ($urandom_range(0, 1) == 1);
            #1;
            check("rnd_usage", 64'(b_usage), 64'(sb.size()));
            check("rnd_out_valid", 64'(b_out_valid), (sb.size() != 0) ? 64'd1 : 64'd0);
            check("rnd_in_ready", 64'(b_in_ready), (sb.size() != 3) ? 64'd1 : 64'd0);
            do_push = b_in_valid && b_in_ready;
            do_pop  = b_out_valid && b_out_ready;
            if (do_pop && sb.size() != 0) begin
                check("rnd_tag", 64'(b_tag_o), 64'(sb[0].tag));
                check("rnd_result", b_result_o, sb[0].result);
                check("rnd_status", 64'(b_status_o), 64'(sb[0].status));
            end
            usage_before = b_usage;
            @(posedge clk);
            #1;
            if (do_pop && sb.size() != 0) begin
                b_exp_flags = b_exp_flags | sb[0].status;
                void'(sb.pop_front());
            end
            if (do_push) begin
                sb.push_back('{b_result, b_status, b_tag});
            end
            if (do_push && do_pop) begin
                check("rnd_usage_pushpop", 64'(b_usage), 64'(usage_before));
            end
            hold = b_in_valid && !do_push;
        end
        check("rnd_flags", 64'(b_flags), FlagsOn ? 64'(b_exp_flags) : 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
